cordic_gain_comp: RTL

- Downstream stage of the combinational CORDIC rotator.
- Removes the CORDIC gain (~1.64676) from the rotator's X/Y (or cos/sin) outputs by multiplying both channels by K ≈ 0.6072529350 in Q3.29.
- Uses a serial shift-add multiplier with a valid/ready handshake on both sides.
- Applies an optional quadrant negation supplied by the upstream angle-reduction logic.

---
 rtl/cordic_pkg.sv | 7 +
 rtl/cordic_gain_mac.sv | 46 ++++
 rtl/cordic_gain_comp.sv | 68 ++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: Q3.29 constants, CORDIC gain-compensation constant and FSM state type
package cordic_pkg;
  localparam int Q_FRAC = 29;
  localparam logic [31:0] Q_ONE = 32'h2000_0000;
  localparam logic [31:0] K_Q = 32'h136E_9DB5;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
endpackage

// File: rtl/cordic_gain_mac.sv
// cordic_gain_mac: one channel of the serial shift-add K multiplier with round and negate
// CORDIC_GAIN_RADIX4_EN retires two K bits per step.
module cordic_gain_mac
  import cordic_pkg::*;
#(
  parameter int N = 32,
  parameter int FRAC = Q_FRAC,
  parameter int G = 4,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          acc_en,
  input  logic          fin,
  input  logic          neg,
  input  logic [SW-1:0] step,
  input  logic [N-1:0]  d,
  output logic [N-1:0]  q
);
  localparam int W = N + G + 1;
  localparam int KI = $clog2(N);
  localparam logic signed [W-1:0] Z = '0;
  logic signed [W-1:0] op, acc, add, r;
`ifdef CORDIC_GAIN_RADIX4_EN
  int s2;
  always_comb begin
    s2 = 2 * int'(step);
    add = (K_Q[KI'(FRAC + 2 - s2)] ? op >>> (s2 - 2) : Z) + (K_Q[KI'(FRAC + 1 - s2)] ? op >>> (s2 - 1) : Z);
  end
`else
  assign add = K_Q[KI'(FRAC - int'(step))] ? op >>> step : Z;
`endif
  // round half up at the Q3.29 LSB before dropping the guard bits
  assign r = acc + W'(1 << (G - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op <= '0;
      acc <= '0;
      q <= '0;
    end else if (load) begin
      op <= {d[N-1], d, G'(0)};
      acc <= '0;
    end else if (acc_en) acc <= acc + add;
    else if (fin) q <= neg ? -N'(r >>> G) : N'(r >>> G);
endmodule

// File: rtl/cordic_gain_comp.sv
// cordic_gain_comp: removes CORDIC gain from rotator X/Y by multiplying with K, optional pi negation
// Build option: CORDIC_GAIN_RADIX4_EN (two K bits per cycle, bit-identical results).
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int N = 32,
  parameter int FRAC = Q_FRAC,
  parameter int G = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_x,
  input  logic [N-1:0] in_y,
  input  logic         in_neg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_x,
  output logic [N-1:0] out_y
);
`ifdef CORDIC_GAIN_RADIX4_EN
  localparam int STEPS = (FRAC + 1) / 2;
`else
  localparam int STEPS = FRAC;
`endif
  localparam int SW = $clog2(STEPS + 2);
  // the step after the last accumulation registers the rounded result
  localparam logic [SW-1:0] LAST = SW'(STEPS + 1);
  state_t state;
  logic [SW-1:0] step;
  logic neg, load, acc_en, fin;
  assign in_ready = state == IDLE && !rst;
  assign load = in_valid && in_ready;
  assign acc_en = state == MUL && step != LAST;
  assign fin = state == MUL && step == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      step <= '0;
      neg <= 1'b0;
      out_valid <= 1'b0;
    end else
      case (state)
        IDLE: if (load) begin
          state <= MUL;
          step <= SW'(1);
          neg <= in_neg;
        end
        MUL: if (fin) begin
          state <= DONE;
          out_valid <= 1'b1;
        end else step <= step + 1'b1;
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
  cordic_gain_mac #(.N(N), .FRAC(FRAC), .G(G), .SW(SW)) u_x (
    .clk(clk), .rst(rst), .load(load), .acc_en(acc_en), .fin(fin), .neg(neg),
    .step(step), .d(in_x), .q(out_x)
  );
  cordic_gain_mac #(.N(N), .FRAC(FRAC), .G(G), .SW(SW)) u_y (
    .clk(clk), .rst(rst), .load(load), .acc_en(acc_en), .fin(fin), .neg(neg),
    .step(step), .d(in_y), .q(out_y)
  );
endmodule
